// File: rtl/fsub_round_pack_if.sv
// Handshake and data bundle between the subtract stage, this block and its consumer.
// FSUB_STAT_CNT_EN adds the saturating overflow/underflow counters.
interface fsub_round_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [24:0] m_in;
  logic        round_in;
  logic [7:0]  exp_big;
  logic [7:0]  norm_shift;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ovf;
  logic        unf;
  logic        zero;
`ifdef FSUB_STAT_CNT_EN
  logic [15:0] ovf_cnt;
  logic [15:0] unf_cnt;
`endif

  modport slave (
    input  in_valid, sign_in, m_in, round_in,
    input  exp_big, norm_shift, out_ready,
    output in_ready, out_valid, result,
    output ovf, unf, zero
`ifdef FSUB_STAT_CNT_EN
    , output ovf_cnt, unf_cnt
`endif
  );

  modport master (
    output in_valid, sign_in, m_in, round_in,
    output exp_big, norm_shift, out_ready,
    input  in_ready, out_valid, result,
    input  ovf, unf, zero
`ifdef FSUB_STAT_CNT_EN
    , input ovf_cnt, unf_cnt
`endif
  );
endinterface

// File: rtl/fsub_round_pack.sv
// Round, exponent fix-up and binary32 pack: two-stage valid/ready pipeline.
// FSUB_STAT_CNT_EN enables saturating ovf/unf transfer counters.
module fsub_round_pack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic             clk,
  input logic             rst,
  fsub_round_pack_if.slave bus
);
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EMAX =
    {2'b00, {EXP_W{1'b1}}};

  logic                 s1_valid_q;
  logic                 s1_sign_q;
  logic                 s1_zero_q;
  logic [MAN_W:0]       s1_frac_q;
  logic signed [EW-1:0] s1_exp_q;

  logic                 s2_valid_q;
  logic [31:0]          s2_res_q;
  logic                 s2_ovf_q;
  logic                 s2_unf_q;
  logic                 s2_zero_q;

  logic                 s1_load;
  logic                 s2_load;
  logic [MAN_W:0]       frac_d;
  logic signed [EW-1:0] exp_d;

  logic                 carry;
  logic signed [EW-1:0] e_f;
  logic [MAN_W-1:0]     frac_f;
  logic [31:0]          res_d;
  logic                 ovf_d;
  logic                 unf_d;
  logic                 zero_d;

  assign s2_load      = !s2_valid_q || bus.out_ready;
  assign s1_load      = !s1_valid_q || s2_load;
  assign bus.in_ready = s1_load;

  assign frac_d = {1'b0, bus.m_in[MAN_W:1]}
                + {{MAN_W{1'b0}}, bus.round_in};
  assign exp_d  = $signed({2'b00, bus.exp_big})
                - $signed({2'b00, bus.norm_shift});

  // Rounding carry renormalizes: fraction wraps to 0, exponent bumps.
  assign carry  = s1_frac_q[MAN_W];
  assign e_f    = s1_exp_q
                + $signed({{(EW-1){1'b0}}, carry});
  assign frac_f = carry ? '0 : s1_frac_q[MAN_W-1:0];

  always_comb begin
    res_d  = '0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    zero_d = 1'b0;
    if (s1_zero_q) begin
      zero_d = 1'b1;
    end else if (e_f <= 0) begin
      res_d = {s1_sign_q, 31'b0};
      unf_d = 1'b1;
    end else if (e_f >= EMAX) begin
      res_d = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_d = 1'b1;
    end else begin
      res_d = {s1_sign_q, e_f[EXP_W-1:0], frac_f};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_frac_q  <= '0;
      s1_exp_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_ovf_q   <= 1'b0;
      s2_unf_q   <= 1'b0;
      s2_zero_q  <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_sign_q <= bus.sign_in;
          s1_zero_q <= (bus.m_in == '0);
          s1_frac_q <= frac_d;
          s1_exp_q  <= exp_d;
        end
      end
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        s2_res_q   <= s1_valid_q ? res_d : '0;
        s2_ovf_q   <= s1_valid_q && ovf_d;
        s2_unf_q   <= s1_valid_q && unf_d;
        s2_zero_q  <= s1_valid_q && zero_d;
      end
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.result    = s2_res_q;
  assign bus.ovf       = s2_ovf_q;
  assign bus.unf       = s2_unf_q;
  assign bus.zero      = s2_zero_q;

`ifdef FSUB_STAT_CNT_EN
  logic        xfer;
  logic [15:0] ovf_cnt_q;
  logic [15:0] ovf_cnt_d;
  logic [15:0] unf_cnt_q;
  logic [15:0] unf_cnt_d;

  assign xfer = s2_valid_q && bus.out_ready;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    unf_cnt_d = unf_cnt_q;
    if (xfer && s2_ovf_q && ovf_cnt_q != 16'hFFFF)
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    if (xfer && s2_unf_q && unf_cnt_q != 16'hFFFF)
      unf_cnt_d = unf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      unf_cnt_q <= unf_cnt_d;
    end
  end

  assign bus.ovf_cnt = ovf_cnt_q;
  assign bus.unf_cnt = unf_cnt_q;
`endif
endmodule

// File: doc/fsub_round_pack.md
Name: fsub_round_pack

Overview:
- Downstream neighbour of the mantissa subtract/normalize stage of the FP adder datapath.
- Consumes the normalized 25-bit mantissa, round bit, larger-operand exponent and normalization shift.
- Applies rounding, computes the final exponent with overflow/underflow detection, and packs an IEEE-754 single-precision word.
- 2-stage registered pipeline with valid/ready handshake on both sides; the input register and the output register are the two pipeline stages.

Parameters:
- EXP_W, 8, exponent width (fixed for binary32; stated for clarity, only 8 supported).
- MAN_W, 23, stored fraction width (only 23 supported).

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream result present
- in_ready  output  1  stage can accept this cycle
- sign_in  input  1  sign of result
- m_in  input  25  normalized mantissa: bit24 implicit 1, bits23:1 fraction, bit0 guard (ignored)
- round_in  input  1  round-up request from subtract stage
- exp_big  input  8  exponent of larger operand
- norm_shift  input  8  left-shift applied during normalization
- out_valid  output  1  packed result present
- out_ready  input  1  downstream accepts
- result  output  32  {sign, exp[7:0], frac[22:0]}
- ovf  output  1  result overflowed to infinity
- unf  output  1  result flushed to zero (exponent ≤ 0)
- zero  output  1  exact zero result

Behaviour:
- Reset: all valids 0, in_ready 1 after reset, result 0, ovf/unf/zero 0. Reset mid-flight discards both stages, no output.
- Handshake: transfer when valid & ready. s2_load = !s2_valid | out_ready. s1_load = !s1_valid | s2_load. in_ready = s1_load (combinational from out_ready; no skid buffer).
- Simultaneous in-accept and out-accept: both stages advance the same cycle; full throughput 1 result/cycle.
- Output data and flags held stable while out_valid & !out_ready.
- Latency: 2 cycles from accepted input to out_valid when not stalled.
- Stage 1 (registered on accept):
  - frac_r = m_in[23:1] + round_in, computed 24-bit; carry = bit23 overflow (frac all ones and round_in).
  - e_r = {2'b0,exp_big} - {2'b0,norm_shift}, computed 10-bit signed.
  - zero_r = (m_in == 0).
- Stage 2 (registered on s2_load):
  - e_f = e_r + carry.
  - frac_f = carry ? 0 : frac_r[22:0].
  - Priority:
    1. zero_r → result 32'h00000000 (always +0, sign ignored), zero=1.
    2. e_f ≤ 0 → {sign,31'b0}, unf=1.
    3. e_f ≥ 255 → {sign,8'hFF,23'b0}, ovf=1.
    4. Otherwise {sign,e_f[7:0],frac_f}.
  - Flags mutually exclusive; valid only alongside out_valid.

Optional Feature:
- FSUB_STAT_CNT_EN defined:
  - Adds outputs ovf_cnt[15:0] and unf_cnt[15:0].
  - Each increments by 1 on every output transfer (out_valid & out_ready) carrying that flag; saturates at 16'hFFFF; cleared by rst.
- FSUB_STAT_CNT_EN undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- exp_big=127, norm_shift=1, m_in=25'h1000000, round_in=0, sign=0 → after 2 cycles result=32'h3F000000, all flags 0.
- exp_big=127, norm_shift=0, m_in=25'h1FFFFFF, round_in=1 → rounding carry, result=32'h40000000.
- exp_big=254, norm_shift=0, m_in=25'h1FFFFFE, round_in=1, sign=1 → result=32'hFF800000, ovf=1 (counter 1 when FSUB_STAT_CNT_EN is defined).
- exp_big=3, norm_shift=5, m_in=25'h1000000, sign=1 → result=32'h80000000, unf=1; m_in=0, sign=1 → result=32'h00000000, zero=1.
- Four back-to-back inputs with out_ready low for 3 cycles: in_ready drops after the 2 stages fill, result stable while stalled, all 4 delivered in order, none lost or duplicated.
- rst asserted for 1 cycle with both stages valid → out_valid 0 next cycle, in_ready 1, no stale result emitted afterwards.
